// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with one-entry skid buffer; ports: clk, r (async reset), flush, in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data/out_datab downstream, count occupancy 0..2
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_datab,
  output logic [1:0]       count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_main, r_skid;
  logic             w_acc, w_drn, w_ld_main, w_ld_skid, w_from_skid;
  assign out_valid = r_state != EMPTY;
  assign in_ready  = r_state != FULL;
  assign count     = r_state;
  assign out_data  = r_main;
  assign out_datab = ~r_main;
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;
  always_comb begin
    w_next      = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_from_skid = 1'b0;
    if (flush) w_next = EMPTY;
    else
      case (r_state)
        EMPTY: if (w_acc) begin
          w_next    = ONE;
          w_ld_main = 1'b1;
        end
        ONE: if (w_acc && w_drn) w_ld_main = 1'b1;
        else if (w_acc) begin
          w_next    = FULL;
          w_ld_skid = 1'b1;
        end else if (w_drn) w_next = EMPTY;
        FULL: if (w_drn) begin
          w_next      = ONE;
          w_ld_main   = 1'b1;
          w_from_skid = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
  end
  always_ff @(posedge clk or posedge r)
    if (r) begin
      r_state <= EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_next;
      if (w_ld_main) r_main <= w_from_skid ? r_skid : in_data;
      if (w_ld_skid) r_skid <= in_data;
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus scoreboard-checked random traffic for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam logic [31:0] RV = 32'hA5A5_0000;
  logic        clk = 1'b0, r = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data, out_datab;
  logic [1:0]  count;
  int          checks = 0, failures = 0;
  logic [31:0] q[$];
  typedef struct {
    logic        fl, iv;
    logic [31:0] d;
    logic        ordy, ev, erdy;
    logic [1:0]  ec;
    logic [31:0] ed;
  } vec_t;
  vec_t tv[20];
  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV)) dut (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_datab(out_datab), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush = fl;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{1'b0, 1'b1, 32'd1,  1'b0, 1'b1, 1'b1, 2'd1, 32'd1};
    tv[1]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 2'd0, 32'd1};
    tv[2]  = '{1'b0, 1'b1, 32'd1,  1'b1, 1'b1, 1'b1, 2'd1, 32'd1};
    tv[3]  = '{1'b0, 1'b1, 32'd2,  1'b1, 1'b1, 1'b1, 2'd1, 32'd2};
    tv[4]  = '{1'b0, 1'b1, 32'd3,  1'b1, 1'b1, 1'b1, 2'd1, 32'd3};
    tv[5]  = '{1'b0, 1'b1, 32'd4,  1'b1, 1'b1, 1'b1, 2'd1, 32'd4};
    tv[6]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 2'd0, 32'd4};
    tv[7]  = '{1'b0, 1'b1, 32'd10, 1'b0, 1'b1, 1'b1, 2'd1, 32'd10};
    tv[8]  = '{1'b0, 1'b1, 32'd11, 1'b0, 1'b1, 1'b0, 2'd2, 32'd10};
    tv[9]  = '{1'b0, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 2'd2, 32'd10};
    tv[10] = '{1'b0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b1, 2'd1, 32'd11};
    tv[11] = '{1'b0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b1, 2'd1, 32'd12};
    tv[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 2'd0, 32'd12};
    tv[13] = '{1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 1'b1, 2'd1, 32'd20};
    tv[14] = '{1'b0, 1'b1, 32'd21, 1'b0, 1'b1, 1'b0, 2'd2, 32'd20};
    tv[15] = '{1'b1, 1'b1, 32'd22, 1'b1, 1'b0, 1'b1, 2'd0, 32'd20};
    tv[16] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 2'd0, 32'd20};
    tv[17] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 2'd0, 32'd20};
    tv[18] = '{1'b0, 1'b1, 32'd30, 1'b0, 1'b1, 1'b1, 2'd1, 32'd30};
    tv[19] = '{1'b0, 1'b1, 32'd31, 1'b0, 1'b1, 1'b0, 2'd2, 32'd30};
    #3 r = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_data", out_data, RV);
    chk("rst_out_datab", out_datab, 32'h5A5A_FFFF);
    drive(1'b0, 1'b1, 32'hDEAD, 1'b0);
    #18 r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].fl, tv[i].iv, tv[i].d, tv[i].ordy);
      step();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].erdy});
      chk($sformatf("v%0d_count", i), {30'd0, count}, {30'd0, tv[i].ec});
      chk($sformatf("v%0d_out_data", i), out_data, tv[i].ed);
      chk($sformatf("v%0d_out_datab", i), out_datab, ~tv[i].ed);
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    #2 r = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", {30'd0, count}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_out_data", out_data, RV);
    #2 r = 1'b0;
    drive(1'b0, 1'b1, 32'd7, 1'b0);
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", out_data, 32'd7);
    chk("post_rst_count", {30'd0, count}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    chk("post_rst_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_drain_count", {30'd0, count}, 32'd0);
    begin
      int   words = 0, cyc = 0;
      logic ir0;
      while (words < 10000 && cyc < 40000) begin
        cyc++;
        ir0 = in_ready;
        chk("rnd_count", {30'd0, count}, q.size());
        chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        drive(1'b0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
        #1;
        chk("rnd_in_ready_comb", {31'd0, in_ready}, {31'd0, ir0});
        out_ready = ~out_ready;
        #1;
        chk("rnd_in_ready_comb2", {31'd0, in_ready}, {31'd0, ir0});
        out_ready = ~out_ready;
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
          else chk("rnd_data", out_data, q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back(in_data);
          words++;
        end
        step();
      end
      if (words < 10000) chk("rnd_timeout_words", words, 32'd10000);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 6 && q.size() != 0; i++) begin
        #1;
        if (out_valid) chk("tail_data", out_data, q.pop_front());
        step();
      end
      chk("tail_empty", q.size(), 32'd0);
      chk("tail_count", {30'd0, count}, 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
